// File: rtl/sprite_blit_scheduler_pkg.sv
// rtl/sprite_blit_scheduler_pkg.sv - shared frame-buffer constants, sprite codes, pixel format and FSM states
package fb_pkg;

  localparam int FB_W = 320;
  localparam int FB_H = 480;

  typedef enum logic [4:0] {
    SHIP     = 5'd0,
    PAC_1    = 5'd1,
    ENEMY2_2 = 5'd10,
    BKG2     = 5'd15,
    BKG1     = 5'd31
  } sprite_code_e;

  // Byte stored in the frame buffer; the palette stage splits it at scan-out.
  typedef struct packed {
    logic [4:0] sel;
    logic [2:0] idx;
  } fb_pixel_t;

  // GRANT is the gnt cycle, RUN walks the raster, ACK is the final write slot.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_ACK   = 2'd3
  } blit_state_e;

endpackage

// File: rtl/sprite_blit_scheduler_if.sv
// rtl/sprite_blit_scheduler_if.sv - requester, sprite ROM and frame-buffer signals of the blit scheduler
interface sprite_blit_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 16,
  parameter int ADDR_W = 18
);
  localparam int ROM_AW = 5 + $clog2(SPR_H) + $clog2(SPR_W);

  logic                  draw_en;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][4:0]  req_sel;
  logic [NREQ-1:0][8:0]  req_x;
  logic [NREQ-1:0][8:0]  req_y;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [ROM_AW-1:0]     rom_addr;
  logic [2:0]            rom_data;
  logic                  fb_we;
  logic [ADDR_W-1:0]     fb_addr;
  logic [7:0]            fb_wdata;

  // Scheduler side
  modport master (
    input  draw_en, req, req_sel, req_x, req_y, rom_data,
    output gnt, ack, busy, rom_addr, fb_we, fb_addr, fb_wdata
  );

  // Requesters, sprite ROM and frame buffer side
  modport slave (
    output draw_en, req, req_sel, req_x, req_y, rom_data,
    input  gnt, ack, busy, rom_addr, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/sprite_blit_scheduler_rr_arbiter.sv
// rtl/sprite_blit_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts after i_ptr
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic                    o_valid
);

  // Two passes: first requesters above the pointer, then wrap to 0..ptr.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[i] && (i > int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        o_valid  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[i] && (i <= int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blit_scheduler.sv
// rtl/sprite_blit_scheduler.sv - round-robin sprite blitter sharing the frame-buffer write port
module sprite_blit_scheduler #(
  parameter int NREQ   = 4,
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 16,
  parameter int FB_W   = fb_pkg::FB_W,
  parameter int FB_H   = fb_pkg::FB_H,
  parameter int ADDR_W = 18
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  sprite_blit_scheduler_if.master bus
);
  import fb_pkg::*;

  localparam int CW    = $clog2(SPR_W);
  localparam int RW    = $clog2(SPR_H);
  localparam int KW    = CW + RW;
  localparam int PTR_W = $clog2(NREQ);

  blit_state_e       r_state;
  blit_state_e       w_next;
  logic [PTR_W-1:0]  r_ptr;
  logic [NREQ-1:0]   r_cur;
  logic [4:0]        r_sel;
  logic [8:0]        r_x;
  logic [8:0]        r_y;
  logic [KW-1:0]     r_k;
  logic              r_wv;
  logic [ADDR_W-1:0] r_waddr;

  logic [NREQ-1:0]   w_gnt;
  logic              w_valid;
  logic [PTR_W-1:0]  w_idx;
  logic              w_start;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic [9:0]        w_px;
  logic [9:0]        w_py;
  logic              w_inside;
  logic [ADDR_W-1:0] w_addr;
  fb_pixel_t         w_pix;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  // One-hot winner to index, used for operand select and the new pointer.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_idx = PTR_W'(i);
    end
  end

  // Raster position of the pixel being fetched, clip test and FB address (10-bit sums never wrap).
  always_comb begin
    w_start  = (r_state == ST_IDLE) && bus.draw_en && w_valid;
    w_col    = r_k[CW-1:0];
    w_row    = r_k[KW-1:CW];
    w_px     = 10'(r_x) + 10'(w_col);
    w_py     = 10'(r_y) + 10'(w_row);
    w_inside = (w_px < 10'(FB_W)) && (w_py < 10'(FB_H));
    w_addr   = ADDR_W'(w_py) * ADDR_W'(FB_W) + ADDR_W'(w_px);
  end

  // FSM state register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= ST_IDLE;
    else              r_state <= w_next;
  end

  // FSM next state: the last raster pixel moves RUN into the ack slot.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_GRANT;
      ST_GRANT: w_next = ST_RUN;
      ST_RUN:   if (r_k == {KW{1'b1}}) w_next = ST_ACK;
      ST_ACK:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operand latch, pointer update, raster counter and one-stage write pipeline.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_ptr   <= PTR_W'(NREQ - 1);
      r_cur   <= '0;
      r_sel   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_k     <= '0;
      r_wv    <= 1'b0;
      r_waddr <= '0;
    end else begin
      if (w_start) begin
        r_cur <= w_gnt;
        r_ptr <= w_idx;
        r_sel <= bus.req_sel[w_idx];
        r_x   <= bus.req_x[w_idx];
        r_y   <= bus.req_y[w_idx];
      end
      if (r_state == ST_GRANT)    r_k <= '0;
      else if (r_state == ST_RUN) r_k <= r_k + 1'b1;
      r_wv    <= (r_state == ST_RUN) && w_inside;
      r_waddr <= w_addr;
    end
  end

  // Outputs decoded from registered state; a zero palette index is transparent.
  always_comb begin
    w_pix.sel    = r_sel;
    w_pix.idx    = bus.rom_data;
    bus.gnt      = (r_state == ST_GRANT) ? r_cur : '0;
    bus.ack      = (r_state == ST_ACK) ? r_cur : '0;
    bus.busy     = (r_state != ST_IDLE);
    bus.rom_addr = {r_sel, r_k};
    bus.fb_we    = r_wv && (bus.rom_data != 3'd0);
    bus.fb_addr  = r_waddr;
    bus.fb_wdata = w_pix;
  end

endmodule
